// File: rtl/rep5_serial_tx.sv
// rtl/rep5_serial_tx.sv - repetition-code serial transmitter, LSB first
// Each data bit is sent REP times in a row; first/last flags frame the word.
module rep5_serial_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_first,
  output logic              tx_last,
  output logic              busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int RW = $clog2(REP);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] sh, sh_nx;
  logic [BW-1:0]     bit_idx, bit_idx_nx;
  logic [RW-1:0]     rep_cnt, rep_cnt_nx;
  logic              in_fire, tx_fire;

  assign tx_valid = (state == SEND);
  assign busy     = tx_valid;
  assign tx_bit   = sh[0];
  assign tx_first = tx_valid && (bit_idx == '0) && (rep_cnt == '0);
  assign tx_last  = tx_valid && (bit_idx == BIT_LAST) && (rep_cnt == REP_LAST);
  assign tx_fire  = tx_valid && tx_ready;
  // Accepting on the last handshake lets the next frame follow with no gap.
  assign in_ready = (state == IDLE) || (tx_last && tx_fire);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh      <= '0;
      bit_idx <= '0;
      rep_cnt <= '0;
    end else begin
      state   <= state_nx;
      sh      <= sh_nx;
      bit_idx <= bit_idx_nx;
      rep_cnt <= rep_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sh_nx      = sh;
    bit_idx_nx = bit_idx;
    rep_cnt_nx = rep_cnt;
    case (state)
      IDLE: begin
        if (in_fire) begin
          state_nx   = SEND;
          sh_nx      = in_data;
          bit_idx_nx = '0;
          rep_cnt_nx = '0;
        end
      end
      SEND: begin
        if (tx_fire) begin
          if (tx_last) begin
            if (in_fire) begin
              sh_nx      = in_data;
              bit_idx_nx = '0;
              rep_cnt_nx = '0;
            end else begin
              state_nx = IDLE;
            end
          end else if (rep_cnt != REP_LAST) begin
            rep_cnt_nx = rep_cnt + 1'b1;
          end else begin
            rep_cnt_nx = '0;
            bit_idx_nx = bit_idx + 1'b1;
            sh_nx      = sh >> 1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rep5_serial_tx.sv
// tb/tb_rep5_serial_tx.sv - self-checking bench for rep5_serial_tx
// Frame-level reference model, table vectors, corner sequences and majority loopback.
module tb_rep5_serial_tx;

  localparam int DW = 8;
  localparam int RP = 5;
  localparam int N  = DW * RP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          tx_bit, tx_valid, tx_first, tx_last, busy;
  logic          tx_ready = 1'b1;

  int total = 0;
  int bad = 0;
  bit rnd_mode = 1'b0;

  logic [DW-1:0] acc_q[$];
  logic [N-1:0]  frames_q[$];
  int            sym_idx = 0;
  int            frames_done = 0;

  rep5_serial_tx #(.DATA_W(DW), .REP(RP)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_first(tx_first), .tx_last(tx_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every accepted symbol with the frame expected from the accepted words.
  initial begin
    logic         prev_stall, prev_in_fire;
    logic [2:0]   prev_out;
    logic [N-1:0] cur;
    logic [DW-1:0] w;
    prev_stall = 1'b0;
    prev_in_fire = 1'b0;
    prev_out = '0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sym_idx = 0;
        cur = '0;
        acc_q.delete();
        prev_stall = 1'b0;
        prev_in_fire = 1'b0;
      end else begin
        chk("busy_eq_valid", 64'(busy), 64'(tx_valid));
        chk("in_ready_rule", 64'(in_ready), 64'(!tx_valid || (tx_last && tx_ready)));
        if (prev_in_fire) chk("first_latency", {tx_valid, tx_first}, 2'b11);
        if (prev_stall)
          chk("stall_hold", {tx_valid, tx_bit, tx_first, tx_last}, {1'b1, prev_out});
        if (tx_valid && tx_ready) begin
          if (acc_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL orphan_symbol got=symbol exp=none");
          end else begin
            w = acc_q[0];
            chk("symbol", {tx_bit, tx_first, tx_last},
                {w[sym_idx / RP], sym_idx == 0, sym_idx == N - 1});
            if (sym_idx < N) cur[sym_idx] = tx_bit;
            if (tx_last || sym_idx >= N - 1) begin
              void'(acc_q.pop_front());
              frames_q.push_back(cur);
              frames_done++;
              sym_idx = 0;
              cur = '0;
            end else begin
              sym_idx++;
            end
          end
        end
        prev_in_fire = in_valid && in_ready;
        if (prev_in_fire) acc_q.push_back(in_data);
        prev_stall = tx_valid && !tx_ready;
        prev_out = {tx_bit, tx_first, tx_last};
      end
    end
  end

  // All stimulus tasks start and end at posedge+2.
  task automatic put_word(input logic [DW-1:0] w);
    int n;
    n = 0;
    in_data = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("put_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic get_frame(output logic [N-1:0] s);
    int n;
    n = 0;
    while (frames_q.size() == 0 && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (frames_q.size() == 0) begin
      chk("frame_timeout", 64'd0, 64'd1);
      s = '0;
    end else begin
      s = frames_q.pop_front();
    end
  endtask

  function automatic logic [DW-1:0] vote_decode(input logic [N-1:0] s);
    logic [DW-1:0] d;
    logic [RP-1:0] grp;
    int a, b, ones;
    d = '0;
    for (int g = 0; g < DW; g++) begin
      grp = s[g*RP +: RP];
      a = $urandom_range(0, RP - 1);
      b = (a + 1 + $urandom_range(0, RP - 2)) % RP;
      grp[a] = ~grp[a];
      grp[b] = ~grp[b];
      ones = 0;
      for (int k = 0; k < RP; k++) ones += int'(grp[k]);
      d[g] = (ones > RP / 2);
    end
    return d;
  endfunction

  typedef struct {
    logic [DW-1:0] w;
    bit            rnd;
    logic [N-1:0]  exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [N-1:0] fr;
    logic [DW-1:0] w;
    int vcnt, rcnt, cyc, first2, n;
    bit drop;

    vecs[0] = '{8'hA5, 1'b0, 40'hF83E007C1F};
    vecs[1] = '{8'h3C, 1'b1, 40'h003FFFFC00};
    vecs[2] = '{8'hFF, 1'b0, 40'hFFFFFFFFFF};
    vecs[3] = '{8'h00, 1'b1, 40'h0000000000};
    vecs[4] = '{8'h01, 1'b0, 40'h000000001F};
    vecs[5] = '{8'h80, 1'b1, 40'hF800000000};

    #1;
    chk("reset_outs", {in_ready, tx_valid, tx_bit, tx_first, tx_last, busy}, 6'b100000);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    for (int i = 0; i < 6; i++) begin
      rnd_mode = vecs[i].rnd;
      put_word(vecs[i].w);
      get_frame(fr);
      chk($sformatf("vec%0d_frame", i), 64'(fr), 64'(vecs[i].exp));
      @(posedge clk);
      #2;
      chk($sformatf("vec%0d_idle", i), {busy, tx_valid, in_ready}, 3'b001);
    end
    rnd_mode = 1'b0;

    // Back-to-back frames with in_valid held high.
    in_data = 8'h01;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_data = 8'hFF;
    vcnt = 0; rcnt = 0; cyc = 0; first2 = 0; n = 0;
    while (!(frames_done >= 8 && !tx_valid) && n < 400) begin
      @(negedge clk);
      cyc++;
      n++;
      if (tx_valid) vcnt++;
      if (tx_valid && in_ready) rcnt++;
      if (tx_valid && tx_first && cyc > 1) first2 = cyc;
      drop = in_valid && in_ready && tx_valid;
      @(posedge clk);
      #2;
      if (drop) in_valid = 1'b0;
    end
    chk("b2b_valid_cycles", 64'(vcnt), 64'd80);
    chk("b2b_ready_pulses", 64'(rcnt), 64'd2);
    chk("b2b_first2_cycle", 64'(first2), 64'd41);
    get_frame(fr);
    chk("b2b_frame1", 64'(fr), 64'h000000001F);
    get_frame(fr);
    chk("b2b_frame2", 64'(fr), 64'hFFFFFFFFFF);

    // Input offered while busy is taken only on the last handshake.
    put_word(8'hFF);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (sym_idx < 3 && n < 200);
    @(posedge clk);
    #2;
    in_data = 8'h00;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!in_ready && n < 200);
    chk("ignore_taken_at_last", {in_ready, tx_valid, tx_last}, 3'b111);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    get_frame(fr);
    chk("ignore_frame1", 64'(fr), 64'hFFFFFFFFFF);
    get_frame(fr);
    chk("ignore_frame2", 64'(fr), 64'h0);

    // Reset in the middle of a frame.
    put_word(8'h5A);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (sym_idx < 17 && n < 200);
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", {in_ready, tx_valid, tx_bit, tx_first, tx_last, busy}, 6'b100000);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("midreset_no_frame", 64'(frames_q.size()), 64'd0);
    put_word(8'h81);
    get_frame(fr);
    chk("after_reset_frame", 64'(fr), 64'hF80000001F);

    // Majority-vote loopback with two symbol errors per group.
    rnd_mode = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = DW'($urandom);
      put_word(w);
      get_frame(fr);
      chk("loopback", 64'(vote_decode(fr)), 64'(w));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #2;
      end
    end
    rnd_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
